// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the IF/MEM unified-memory arbiter
// Contents:
//   state_t : access sequencer states (IDLE, ISSUE, WAIT, RESP)
//   grant_t : which pipeline port owns the memory (GNT_I fetch, GNT_D data)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational two-way picker between fetch and data requests
// Ports:
//   i_req      in  fetch port request
//   d_req      in  data port request
//   last_grant in  port that won the previous arbitration
//   valid      out at least one port is requesting
//   grantee    out port to grant; on a tie, the port that did not win last time
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  grant_t last_grant,
  output logic   valid,
  output grant_t grantee
);

  always_comb begin
    valid   = i_req | d_req;
    grantee = GNT_I;
    if (i_req && d_req) begin
      grantee = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end else if (d_req) begin
      grantee = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one fixed-latency single-port memory between IF and MEM stages
// Parameters: AW word-address width, DW data width, LAT read latency after the strobe (>= 1)
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   i_req, i_addr                    fetch request (level, held until i_ready)
//   i_rdata, i_ready                 fetched word, one-cycle completion pulse
//   d_req, d_we, d_addr, d_wdata     data request (level, held until d_ready)
//   d_rdata, d_ready                 load word, one-cycle completion pulse
//   stall_if, stall_mem              pipeline freeze while a port's request is pending
//   m_en, m_we, m_addr, m_wdata      memory strobe and command, one strobe per access
//   m_rdata                          memory read data, valid LAT cycles after m_en
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW  = 7,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int CW = $clog2(LAT + 1);

  if (LAT < 1) begin : g_lat_check
    $error("mem_arbiter: LAT must be at least 1");
  end

  state_t        state_q;
  state_t        state_d;
  grant_t        last_grant_q;
  grant_t        owner_q;
  logic [CW-1:0] cnt_q;
  logic          pick_valid;
  grant_t        pick_grantee;

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .grantee    (pick_grantee)
  );

  // RESP never consults the picker: the requester is still holding the request
  // it is being answered for, so re-arbitration waits for IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == CW'(1)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
      owner_q      <= GNT_I;
      cnt_q        <= '0;
      m_we         <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            last_grant_q <= pick_grantee;
            owner_q      <= pick_grantee;
            if (pick_grantee == GNT_D) begin
              m_addr  <= d_addr;
              m_we    <= d_we;
              m_wdata <= d_wdata;
            end else begin
              m_addr <= i_addr;
              m_we   <= 1'b0;
            end
          end
        end
        ISSUE: cnt_q <= CW'(LAT);
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          // Count 1 marks the cycle in which m_rdata carries the strobed word.
          if (cnt_q == CW'(1) && !m_we) begin
            if (owner_q == GNT_D) d_rdata <= m_rdata;
            else                  i_rdata <= m_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Decoded from registered state, so they clear together with the async reset.
  assign m_en    = (state_q == ISSUE);
  assign i_ready = (state_q == RESP) && (owner_q == GNT_I);
  assign d_ready = (state_q == RESP) && (owner_q == GNT_D);

  assign stall_if  = i_req & ~i_ready;
  assign stall_mem = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a latency-LAT memory model
module tb_mem_arbiter;
  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int NWORD = 1 << AW;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata, m_rdata;
  logic          i_ready, d_ready, stall_if, stall_mem, m_en, m_we;
  logic [AW-1:0] m_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input int a);
    if (a == 5) return 32'h2008_0007;
    return 32'hA500_0000 ^ (a * 32'h0001_0101);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: read data appears exactly LAT cycles after the strobe cycle;
  // non-strobe cycles inject junk so a mistimed capture shows up.
  logic [DW-1:0] mem     [NWORD];
  logic [DW-1:0] rd_pipe [LAT];
  logic          filled = 1'b0;
  assign m_rdata = rd_pipe[LAT-1];
  always @(posedge clk) begin
    if (!filled) begin
      for (int a = 0; a < NWORD; a++) mem[a] <= pat(a);
      filled <= 1'b1;
    end else if (m_en && m_we) begin
      mem[m_addr] <= m_wdata;
    end
    rd_pipe[0] <= m_en ? mem[m_addr] : (32'h0BAD_0000 ^ 32'(cyc));
    for (int s = 1; s < LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
  end

  typedef struct {
    bit            store;
    logic [DW-1:0] data;
  } exp_t;
  exp_t          i_q[$];
  exp_t          d_q[$];
  logic [DW-1:0] ref_mem [NWORD];

  // Monitor: arbitration rule, command capture, latency and read data
  initial begin : monitor
    bit            p_i, p_d, p_dwe, last_d, men_d, exp_d;
    logic [AW-1:0] p_ia, p_da, men_addr;
    logic [DW-1:0] p_dwd, i_hold, d_hold;
    int            men_cyc;
    exp_t          e;
    p_i = 0; p_d = 0; p_dwe = 0; last_d = 0; men_d = 0;
    p_ia = '0; p_da = '0; men_addr = '0; p_dwd = '0;
    i_hold = '0; d_hold = '0; men_cyc = -100;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        i_q.delete(); d_q.delete();
        last_d = 0; men_cyc = -100; i_hold = '0; d_hold = '0;
      end else begin
        if (m_en) begin
          exp_d = (p_i && p_d) ? !last_d : p_d;
          chk("strobe_has_request", 32'(p_i || p_d), 32'd1);
          chk("strobe_spacing", 32'(cyc - men_cyc >= LAT + 3), 32'd1);
          chk("issue_addr", 32'(m_addr), 32'(exp_d ? p_da : p_ia));
          chk("issue_we", 32'(m_we), 32'(exp_d ? p_dwe : 1'b0));
          if (exp_d && p_dwe) chk("issue_wdata", m_wdata, p_dwd);
          last_d = exp_d; men_d = exp_d; men_cyc = cyc;
          men_addr = exp_d ? p_da : p_ia;
        end
        if (i_ready || d_ready) begin
          chk("ready_latency", 32'(cyc - men_cyc), 32'(LAT + 1));
          chk("ready_port", 32'(d_ready), 32'(men_d));
          chk("ready_single", 32'(i_ready && d_ready), 32'd0);
          chk("addr_held", 32'(m_addr), 32'(men_addr));
        end
        if (i_ready) begin
          if (i_q.size() == 0) chk("i_ready_unexpected", 32'd1, 32'd0);
          else begin
            e = i_q.pop_front();
            i_hold = e.data;
            chk("i_rdata", i_rdata, e.data);
          end
        end else chk("i_rdata_held", i_rdata, i_hold);
        if (d_ready) begin
          if (d_q.size() == 0) chk("d_ready_unexpected", 32'd1, 32'd0);
          else begin
            e = d_q.pop_front();
            if (!e.store) d_hold = e.data;
            chk(e.store ? "d_rdata_after_store" : "d_rdata", d_rdata, d_hold);
          end
        end else chk("d_rdata_held", d_rdata, d_hold);
      end
      p_i = i_req; p_d = d_req; p_ia = i_addr; p_da = d_addr;
      p_dwe = d_we; p_dwd = d_wdata;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    for (int a = 0; a < NWORD; a++) ref_mem[a] = pat(a);

    // Reset held with random requests
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      i_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 1));
      i_addr = AW'($urandom); d_addr = AW'($urandom);
      @(negedge clk);
      chk("rst_m_en", 32'(m_en), 32'd0);
      chk("rst_m_we", 32'(m_we), 32'd0);
      chk("rst_ready", 32'({i_ready, d_ready}), 32'd0);
      chk("rst_m_addr", 32'(m_addr), 32'd0);
      chk("rst_m_wdata", m_wdata, 32'd0);
      chk("rst_rdata", i_rdata | d_rdata, 32'd0);
      chk("rst_stall_if", 32'(stall_if), 32'(i_req));
      chk("rst_stall_mem", 32'(stall_mem), 32'(d_req));
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0; rst_n = 1;
    @(posedge clk); #1;

    // Single fetch
    i_req = 1; i_addr = 5;
    i_q.push_back('{store: 1'b0, data: ref_mem[5]});
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      chk("fetch_stall_if", 32'(stall_if), 32'(k < 4));
      chk("fetch_m_en", 32'(m_en), 32'(k == 1));
      if (k == 1) begin
        chk("fetch_m_addr", 32'(m_addr), 32'd5);
        chk("fetch_m_we", 32'(m_we), 32'd0);
      end
      chk("fetch_i_ready", 32'(i_ready), 32'(k == 4));
      if (k == 4) chk("fetch_i_rdata", i_rdata, 32'h2008_0007);
      @(posedge clk); #1;
    end
    i_req = 0;
    @(posedge clk); #1;

    // Simultaneous requests from IDLE: data first, then fetch
    i_req = 1; i_addr = 20; d_req = 1; d_we = 0; d_addr = 9;
    i_q.push_back('{store: 1'b0, data: ref_mem[20]});
    d_q.push_back('{store: 1'b0, data: ref_mem[9]});
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      chk("sim_m_en", 32'(m_en), 32'(k == 1 || k == 6));
      chk("sim_d_ready", 32'(d_ready), 32'(k == 4));
      chk("sim_i_ready", 32'(i_ready), 32'(k == 9));
      @(posedge clk); #1;
      if (k == 4) d_req = 0;
      if (k == 9) i_req = 0;
    end
    @(posedge clk); #1;

    // Fairness: both held for four accesses, order D I D I
    i_req = 1; i_addr = 10; d_req = 1; d_we = 0; d_addr = 70;
    for (int n = 0; n < 2; n++) begin
      i_q.push_back('{store: 1'b0, data: ref_mem[10]});
      d_q.push_back('{store: 1'b0, data: ref_mem[70]});
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("fair_m_en", 32'(m_en), 32'((k % 5) == 1));
      if ((k % 5) == 1) chk("fair_order_addr", 32'(m_addr), ((k / 5) % 2 == 0) ? 32'd70 : 32'd10);
      @(posedge clk); #1;
      if (k == 19) begin i_req = 0; d_req = 0; end
    end
    @(posedge clk); #1;

    // Store then load of the same address
    d_req = 1; d_we = 1; d_addr = 3; d_wdata = 32'hDEAD_BEEF;
    ref_mem[3] = 32'hDEAD_BEEF;
    d_q.push_back('{store: 1'b1, data: '0});
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("st_m_we", 32'(m_we), 32'd1);
        chk("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
      end
      chk("st_d_ready", 32'(d_ready), 32'(k == 4));
      if (k == 4) chk("st_d_rdata_kept", d_rdata, pat(70));
      @(posedge clk); #1;
    end
    d_we = 0; d_wdata = '0;
    d_q.push_back('{store: 1'b0, data: ref_mem[3]});
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      chk("ld_d_ready", 32'(d_ready), 32'(k == 4));
      if (k == 4) chk("ld_d_rdata", d_rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
    end
    d_req = 0;

    // Randomized traffic: fetches read 0..63, the data port owns 64..127
    fork
      begin : fetch_driver
        int            g;
        logic [AW-1:0] a;
        bit            ok;
        for (int n = 0; n < 40; n++) begin
          g = $urandom_range(0, 3);
          a = AW'($urandom_range(0, 63));
          repeat (g) begin @(posedge clk); #1; end
          i_req = 1; i_addr = a;
          i_q.push_back('{store: 1'b0, data: ref_mem[a]});
          ok = 0;
          for (int t = 0; t < 60 && !ok; t++) begin @(negedge clk); ok = i_ready; end
          chk("fetch_timeout", 32'(ok), 32'd1);
          @(posedge clk); #1;
          i_req = 0;
        end
      end
      begin : data_driver
        int            g;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        bit            we, ok;
        for (int n = 0; n < 40; n++) begin
          g  = $urandom_range(0, 3);
          a  = AW'($urandom_range(64, 127));
          we = 1'($urandom_range(0, 1));
          wd = $urandom;
          repeat (g) begin @(posedge clk); #1; end
          d_req = 1; d_addr = a; d_we = we; d_wdata = wd;
          if (we) begin
            d_q.push_back('{store: 1'b1, data: '0});
            ref_mem[a] = wd;
          end else d_q.push_back('{store: 1'b0, data: ref_mem[a]});
          ok = 0;
          for (int t = 0; t < 60 && !ok; t++) begin @(negedge clk); ok = d_ready; end
          chk("data_timeout", 32'(ok), 32'd1);
          @(posedge clk); #1;
          d_req = 0; d_we = 0;
        end
      end
    join
    repeat (2) begin @(posedge clk); #1; end
    chk("queues_drained", 32'(i_q.size() + d_q.size()), 32'd0);

    // Reset asserted during WAIT
    d_req = 1; d_we = 0; d_addr = 80;
    d_q.push_back('{store: 1'b0, data: ref_mem[80]});
    @(negedge clk); @(negedge clk);
    @(posedge clk); #2;
    rst_n = 0; #1;
    chk("rma_m_en", 32'(m_en), 32'd0);
    chk("rma_d_ready", 32'(d_ready), 32'd0);
    chk("rma_m_addr", 32'(m_addr), 32'd0);
    chk("rma_d_rdata", d_rdata, 32'd0);
    chk("rma_stall_mem", 32'(stall_mem), 32'd1);
    d_req = 0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rma_quiet_m_en", 32'(m_en), 32'd0);
      chk("rma_quiet_ready", 32'({i_ready, d_ready}), 32'd0);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
